sram_march_ctrl: RTL and testbench

Built-in self-test controller that acts as the initiator on the single-port SRAM interface (csn/we/addr/din/dout). On request it runs a March C- sequence over the whole array, checks every read against the expected background, and reports pass/fail with the first failing address and data. It sits beside the SRAM macro and is muxed onto the SRAM port ahead of the AHB-SRAM interface during test mode.

---
 rtl/sram_bist_pkg.sv | 28 ++
 rtl/sram_march_seq.sv | 63 ++++++
 rtl/sram_march_ctrl.sv | 120 ++++++++++++
 tb/tb_sram_march_ctrl.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_bist_pkg.sv
// Shared types for the SRAM March C- BIST: controller states and the per-element
// traversal direction, op count and read/write background of each march element.
package sram_bist_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;

    typedef enum logic [2:0] {M0, M1, M2, M3, M4, M5} march_elem_e;

    localparam int NUM_ELEMS = 6;

    function automatic logic elem_up(input march_elem_e e);
        return (e == M0) || (e == M1) || (e == M2);
    endfunction

    // M0 is write-only and M5 is read-only; every other element is read-then-write.
    function automatic int unsigned elem_ops(input march_elem_e e);
        return ((e == M0) || (e == M5)) ? 1 : 2;
    endfunction

    function automatic logic elem_rd_val(input march_elem_e e);
        return (e == M2) || (e == M4);
    endfunction

    function automatic logic elem_wr_val(input march_elem_e e);
        return (e == M1) || (e == M3);
    endfunction

endpackage

// File: rtl/sram_march_seq.sv
// March C- operation sequencer: walks element index, read/write phase and the
// up/down address counter, presenting the next SRAM operation combinationally.
module sram_march_seq
    import sram_bist_pkg::*;
#(
    parameter int MEM_DEPTH  = 8192,
    parameter int DATA_WIDTH = 8,
    parameter int BITW       = $clog2(MEM_DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  adv,
    output logic                  we,
    output logic [BITW-1:0]       addr,
    output logic [DATA_WIDTH-1:0] din,
    output logic [DATA_WIDTH-1:0] exp_word,
    output logic                  is_read,
    output logic                  last_op
);

    localparam logic [BITW-1:0] ADDR_MAX = BITW'(MEM_DEPTH - 1);

    march_elem_e     elem;
    march_elem_e     elem_nxt;
    logic            phase;
    logic [BITW-1:0] addr_cnt;
    logic            terminal;
    logic            addr_done;

    always_comb begin
        is_read   = (elem != M0) && !phase;
        we        = !is_read;
        addr      = addr_cnt;
        din       = {DATA_WIDTH{elem_wr_val(elem)}};
        exp_word  = {DATA_WIDTH{elem_rd_val(elem)}};
        last_op   = (elem == M5) && (addr_cnt == '0);
        terminal  = elem_up(elem) ? (addr_cnt == ADDR_MAX) : (addr_cnt == '0);
        addr_done = (elem_ops(elem) == 1) || phase;
        // After M5 the sequencer parks on M0 so the next launch starts cleanly.
        elem_nxt  = (elem == M5) ? M0 : march_elem_e'(elem + 3'd1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            elem     <= M0;
            phase    <= 1'b0;
            addr_cnt <= '0;
        end else if (adv) begin
            if (!addr_done) begin
                phase <= 1'b1;
            end else begin
                phase <= 1'b0;
                if (terminal) begin
                    elem     <= elem_nxt;
                    addr_cnt <= elem_up(elem_nxt) ? '0 : ADDR_MAX;
                end else begin
                    addr_cnt <= elem_up(elem) ? addr_cnt + 1'b1 : addr_cnt - 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/sram_march_ctrl.sv
// SRAM March C- BIST controller: run FSM, registered SRAM port, one-cycle read
// compare pipeline and first-failure capture.
module sram_march_ctrl
    import sram_bist_pkg::*;
#(
    parameter int MEM_DEPTH  = 8192,
    parameter int DATA_WIDTH = 8,
    parameter int BITW       = $clog2(MEM_DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  fail,
    output logic [BITW-1:0]       fail_addr,
    output logic [DATA_WIDTH-1:0] fail_data,
    output logic                  sram_csn,
    output logic                  sram_we,
    output logic [BITW-1:0]       sram_addr,
    output logic [DATA_WIDTH-1:0] sram_din,
    input  logic [DATA_WIDTH-1:0] sram_dout
);

    state_e                state, next_state;
    logic                  launch, issue;
    logic                  seq_we, seq_is_read, seq_last;
    logic [BITW-1:0]       seq_addr;
    logic [DATA_WIDTH-1:0] seq_din, seq_exp;
    logic                  rd_vld_p0, rd_vld_p1;
    logic                  end_p0, end_p1;
    logic [DATA_WIDTH-1:0] exp_p0, exp_p1;
    logic [BITW-1:0]       addr_p1;
    logic                  miscompare;

    sram_march_seq #(
        .MEM_DEPTH (MEM_DEPTH),
        .DATA_WIDTH(DATA_WIDTH),
        .BITW      (BITW)
    ) u_seq (
        .clk     (clk),
        .rst     (rst),
        .adv     (issue),
        .we      (seq_we),
        .addr    (seq_addr),
        .din     (seq_din),
        .exp_word(seq_exp),
        .is_read (seq_is_read),
        .last_op (seq_last)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    // RUN stays up until the final read has reached the compare stage.
    always_comb begin
        next_state = state;
        launch     = 1'b0;
        case (state)
            IDLE:    if (start) begin next_state = RUN; launch = 1'b1; end
            RUN:     if (end_p1) next_state = DRAIN;
            DRAIN:   next_state = DONE;
            DONE:    if (start) begin next_state = RUN; launch = 1'b1; end
            default: next_state = IDLE;
        endcase
        issue = launch || ((state == RUN) && !end_p0 && !end_p1);
    end

    assign miscompare = rd_vld_p1 && (sram_dout != exp_p1);

    // p0: operation on the SRAM port; p1: read data returns and is compared.
    always_ff @(posedge clk) begin
        if (rst) begin
            sram_csn  <= 1'b1;
            sram_we   <= 1'b0;
            sram_addr <= '0;
            sram_din  <= '0;
            rd_vld_p0 <= 1'b0;
            rd_vld_p1 <= 1'b0;
            end_p0    <= 1'b0;
            end_p1    <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            fail      <= 1'b0;
            fail_addr <= '0;
            fail_data <= '0;
        end else begin
            sram_csn  <= !issue;
            sram_we   <= issue && seq_we;
            rd_vld_p0 <= issue && seq_is_read;
            end_p0    <= issue && seq_last;
            if (issue) begin
                sram_addr <= seq_addr;
                sram_din  <= seq_din;
            end
            rd_vld_p1 <= rd_vld_p0;
            end_p1    <= end_p0;
            busy      <= (next_state == RUN) || (next_state == DRAIN);
            done      <= (next_state == DONE);
            if (launch) begin
                fail      <= 1'b0;
                fail_addr <= '0;
                fail_data <= '0;
            end else if (miscompare && !fail) begin
                fail      <= 1'b1;
                fail_addr <= addr_p1;
                fail_data <= sram_dout;
            end
        end
    end

    always_ff @(posedge clk) begin
        exp_p0  <= seq_exp;
        exp_p1  <= exp_p0;
        addr_p1 <= sram_addr;
    end

endmodule

// File: tb/tb_sram_march_ctrl.sv
// Bench for sram_march_ctrl on a 16-word SRAM model with injectable stuck-at and
// coupling faults, checked cycle by cycle against a March C- reference model.
module tb_sram_march_ctrl;

    localparam int D  = 16;
    localparam int DW = 8;
    localparam int AW = 4;
    localparam int N  = 10 * D;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          busy, done, fail;
    logic [AW-1:0] fail_addr;
    logic [DW-1:0] fail_data;
    logic          sram_csn, sram_we;
    logic [AW-1:0] sram_addr;
    logic [DW-1:0] sram_din;
    logic [DW-1:0] sram_dout;

    int checks = 0;
    int failures = 0;

    logic [DW-1:0] mem [D];
    bit            sa_en = 0;
    int            sa_addr = 0;
    logic [DW-1:0] sa_mask = '0;
    bit            cf_en = 0;
    int            cf_aggr = 0;
    int            cf_vict = 0;

    bit            op_we   [N];
    logic [AW-1:0] op_addr [N];
    logic [DW-1:0] op_din  [N];
    bit            have_fail;
    int            kf;
    logic [AW-1:0] exp_faddr;
    logic [DW-1:0] exp_fdata;

    always #5 clk = ~clk;

    sram_march_ctrl #(.MEM_DEPTH(D), .DATA_WIDTH(DW), .BITW(AW)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .busy     (busy),
        .done     (done),
        .fail     (fail),
        .fail_addr(fail_addr),
        .fail_data(fail_data),
        .sram_csn (sram_csn),
        .sram_we  (sram_we),
        .sram_addr(sram_addr),
        .sram_din (sram_din),
        .sram_dout(sram_dout)
    );

    function automatic logic [DW-1:0] stored(input int a, input logic [DW-1:0] d);
        return (sa_en && a == sa_addr) ? (d | sa_mask) : d;
    endfunction

    // Faulty single-port SRAM: stuck-at bit on one word, write-1 coupling to a victim.
    always @(posedge clk) begin
        if (!sram_csn) begin
            if (sram_we) begin
                mem[sram_addr] <= stored(int'(sram_addr), sram_din);
                if (cf_en && int'(sram_addr) == cf_aggr && sram_din == 8'hFF)
                    mem[cf_vict] <= 8'hFF;
            end else begin
                sram_dout <= mem[sram_addr];
            end
        end
    end

    task automatic randomize_mem();
        for (int i = 0; i < D; i++) mem[i] = DW'($urandom);
    endtask

    task automatic clear_faults();
        sa_en = 0;
        cf_en = 0;
    endtask

    // Runs March C- on a copy of the current array with the same fault behaviour.
    task automatic build_model();
        logic [DW-1:0] m [D];
        logic [DW-1:0] rv, wv, got;
        int n, a;
        for (int i = 0; i < D; i++) m[i] = mem[i];
        n = 0; have_fail = 0; kf = 0; exp_faddr = '0; exp_fdata = '0;
        for (int e = 0; e < 6; e++) begin
            rv = (e == 2 || e == 4) ? 8'hFF : 8'h00;
            wv = (e == 1 || e == 3) ? 8'hFF : 8'h00;
            for (int i = 0; i < D; i++) begin
                a = (e < 3) ? i : D - 1 - i;
                if (e != 0) begin
                    got = m[a];
                    op_we[n] = 0; op_addr[n] = AW'(a); op_din[n] = '0;
                    if (got !== rv && !have_fail) begin
                        have_fail = 1; kf = n; exp_faddr = AW'(a); exp_fdata = got;
                    end
                    n++;
                end
                if (e != 5) begin
                    op_we[n] = 1; op_addr[n] = AW'(a); op_din[n] = wv;
                    m[a] = stored(a, wv);
                    if (cf_en && a == cf_aggr && wv == 8'hFF) m[cf_vict] = 8'hFF;
                    n++;
                end
            end
        end
    endtask

    task automatic run_and_check(input bit hold, input string name);
        logic [2:0] exp_flags;
        build_model();
        start = 1'b1;
        @(posedge clk);
        #1;
        if (!hold) start = 1'b0;
        for (int c = 0; c <= N + 2; c++) begin
            @(negedge clk);
            checks++;
            if (c < N) begin
                if (sram_csn !== 1'b0 || sram_we !== op_we[c] || sram_addr !== op_addr[c] ||
                    (op_we[c] && sram_din !== op_din[c])) begin
                    failures++;
                    $display("FAIL %s op%0d: got csn=%b we=%b addr=%0d din=%h, want csn=0 we=%b addr=%0d din=%h",
                             name, c, sram_csn, sram_we, sram_addr, sram_din, op_we[c], op_addr[c], op_din[c]);
                end
            end else if (sram_csn !== 1'b1) begin
                failures++;
                $display("FAIL %s idle_csn cycle%0d: got %b want 1", name, c, sram_csn);
            end
            checks++;
            exp_flags = {c < N + 2, c == N + 2, have_fail && c >= kf + 2};
            if ({busy, done, fail} !== exp_flags) begin
                failures++;
                $display("FAIL %s flags cycle%0d: got busy/done/fail=%b want %b",
                         name, c, {busy, done, fail}, exp_flags);
            end
            if (c < N + 2) @(posedge clk);
        end
        checks++;
        if ({fail_addr, fail_data} !== (have_fail ? {exp_faddr, exp_fdata} : {AW'(0), DW'(0)})) begin
            failures++;
            $display("FAIL %s capture: got addr=%0d data=%h want addr=%0d data=%h",
                     name, fail_addr, fail_data, exp_faddr, exp_fdata);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({sram_csn, sram_we, sram_addr, sram_din, busy, done, fail, fail_addr, fail_data} !==
            {1'b1, 1'b0, AW'(0), DW'(0), 3'b000, AW'(0), DW'(0)}) begin
            failures++;
            $display("FAIL reset_state: got csn=%b we=%b addr=%0d din=%h busy=%b done=%b fail=%b fa=%0d fd=%h, want 1 0 0 00 0 0 0 0 00",
                     sram_csn, sram_we, sram_addr, sram_din, busy, done, fail, fail_addr, fail_data);
        end
    endtask

    task automatic test_fault_free();
        clear_faults();
        randomize_mem();
        run_and_check(0, "fault_free");
        for (int i = 0; i < D; i++) begin
            checks++;
            if (mem[i] !== 8'h00) begin
                failures++;
                $display("FAIL final_contents addr%0d: got %h want 00", i, mem[i]);
            end
        end
    endtask

    task automatic test_stuck_at();
        clear_faults();
        sa_en = 1; sa_addr = 5; sa_mask = 8'h08;
        randomize_mem();
        run_and_check(0, "stuck_at");
    endtask

    task automatic test_coupling();
        clear_faults();
        cf_en = 1; cf_aggr = 2; cf_vict = 9;
        randomize_mem();
        run_and_check(0, "coupling");
    endtask

    task automatic test_random_faults();
        for (int it = 0; it < 3; it++) begin
            clear_faults();
            if ($urandom_range(0, 1) == 0) begin
                sa_en = 1;
                sa_addr = $urandom_range(0, D - 1);
                sa_mask = DW'(1) << $urandom_range(0, DW - 1);
            end else begin
                cf_en = 1;
                cf_aggr = $urandom_range(0, D - 1);
                cf_vict = (cf_aggr + 1 + $urandom_range(0, D - 2)) % D;
            end
            randomize_mem();
            run_and_check(0, "random_fault");
        end
    endtask

    task automatic test_reset_mid_run();
        int r;
        bit exp_f;
        clear_faults();
        sa_en = 1; sa_addr = 5; sa_mask = 8'h08;
        randomize_mem();
        build_model();
        r = $urandom_range(40, 60);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (r - 1) @(posedge clk);
        @(negedge clk);
        exp_f = have_fail && (r - 1) >= kf + 2;
        checks++;
        if ({busy, fail, sram_csn} !== {1'b1, exp_f, 1'b0}) begin
            failures++;
            $display("FAIL pre_rst cycle%0d: got busy/fail/csn=%b want %b", r - 1,
                     {busy, fail, sram_csn}, {1'b1, exp_f, 1'b0});
        end
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({sram_csn, busy, done, fail, fail_addr, fail_data} !== {1'b1, 3'b000, AW'(0), DW'(0)}) begin
            failures++;
            $display("FAIL mid_rst: got csn=%b busy=%b done=%b fail=%b fa=%0d fd=%h want 1 0 0 0 0 00",
                     sram_csn, busy, done, fail, fail_addr, fail_data);
        end
        clear_faults();
        run_and_check(0, "after_rst");
    endtask

    task automatic test_back_to_back();
        clear_faults();
        cf_en = 1; cf_aggr = $urandom_range(0, 7); cf_vict = $urandom_range(8, D - 1);
        randomize_mem();
        run_and_check(1, "held_first");
        clear_faults();
        run_and_check(0, "held_second");
    endtask

    initial begin
        test_reset();
        test_fault_free();
        test_stuck_at();
        test_coupling();
        test_random_faults();
        test_reset_mid_run();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
